al_mcu_gpio_bank: RTL and testbench

//   Fabric-side controller for the MCU high GPIO bank, generalised from one pin to NUM_CH pins.
//   Per channel: output data, direction, 2-FF input sync, debounce filter, rise/fall edge capture, sticky W1C irq status.
//   MCU or fabric master accesses it through a simple register port; drives EF2_PHY_MCU gpio_h_* / pad logic.

---
 rtl/al_mcu_gpio_pkg.sv | 16 +
 rtl/al_gpio_debounce.sv | 44 ++++
 rtl/al_mcu_gpio_bank.sv | 136 +++++++++++++
 tb/tb_al_mcu_gpio_bank.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/al_mcu_gpio_pkg.sv
// Shared definitions for the MCU high GPIO bank: register address width and
// register index map seen by the MCU/fabric register port.
package al_mcu_gpio_pkg;

    localparam int ADDR_W = 3;

    localparam logic [ADDR_W-1:0] ADDR_DATA_OUT = 3'd0;
    localparam logic [ADDR_W-1:0] ADDR_DIR      = 3'd1;
    localparam logic [ADDR_W-1:0] ADDR_DATA_IN  = 3'd2;
    localparam logic [ADDR_W-1:0] ADDR_RISE_EN  = 3'd3;
    localparam logic [ADDR_W-1:0] ADDR_FALL_EN  = 3'd4;
    localparam logic [ADDR_W-1:0] ADDR_IRQ_STAT = 3'd5;
    localparam logic [ADDR_W-1:0] ADDR_OUT_SET  = 3'd6;
    localparam logic [ADDR_W-1:0] ADDR_OUT_CLR  = 3'd7;

endpackage

// File: rtl/al_gpio_debounce.sv
// Single-channel debounce filter: a new synchronised level is accepted only
// after DEB_CYCLES consecutive samples that differ from the current output.
module al_gpio_debounce #(
    parameter int DEB_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic filt
);

    generate
        if (DEB_CYCLES <= 1) begin : g_pass
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    filt <= 1'b0;
                end else begin
                    filt <= din;
                end
            end
        end else begin : g_filt
            localparam int CNT_W = $clog2(DEB_CYCLES + 1);
            localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

            logic [CNT_W-1:0] cnt;

            // Counter only runs while the input disagrees; it is cleared on accept so it never wraps.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    filt <= 1'b0;
                    cnt  <= '0;
                end else if (din == filt) begin
                    cnt  <= '0;
                end else if (cnt == CNT_LAST) begin
                    filt <= din;
                    cnt  <= '0;
                end else begin
                    cnt  <= cnt + CNT_W'(1);
                end
            end
        end
    endgenerate

endmodule

// File: rtl/al_mcu_gpio_bank.sv
// Fabric-side GPIO bank controller: output/direction registers, synchronised and
// debounced inputs, edge-triggered sticky interrupt status and a simple register port.
module al_mcu_gpio_bank
    import al_mcu_gpio_pkg::*;
#(
    parameter int NUM_CH     = 16,
    parameter int DEB_CYCLES = 4
) (
    input  logic              ppm_clk,
    input  logic              rst_n,
    input  logic              reg_wr,
    input  logic              reg_rd,
    input  logic [ADDR_W-1:0] reg_addr,
    input  logic [NUM_CH-1:0] reg_wdata,
    output logic [NUM_CH-1:0] reg_rdata,
    output logic              reg_rvalid,
    input  logic [NUM_CH-1:0] gpio_in,
    output logic [NUM_CH-1:0] gpio_out,
    output logic [NUM_CH-1:0] gpio_oe_n,
    output logic              irq
);

    logic [NUM_CH-1:0] data_out;
    logic [NUM_CH-1:0] dir;
    logic [NUM_CH-1:0] rise_en;
    logic [NUM_CH-1:0] fall_en;
    logic [NUM_CH-1:0] irq_stat;
    logic [NUM_CH-1:0] irq_stat_next;
    logic [NUM_CH-1:0] stat_clr;

    logic [NUM_CH-1:0] sync_s1;
    logic [NUM_CH-1:0] sync_s2;
    logic [NUM_CH-1:0] filt;
    logic [NUM_CH-1:0] filt_q;
    logic [NUM_CH-1:0] rise;
    logic [NUM_CH-1:0] fall;
    logic [NUM_CH-1:0] rdata_next;

    assign gpio_out  = data_out;
    assign gpio_oe_n = ~dir;

    // Two-flop synchroniser stage for the asynchronous pad inputs
    always_ff @(posedge ppm_clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_s1 <= '0;
            sync_s2 <= '0;
        end else begin
            sync_s1 <= gpio_in;
            sync_s2 <= sync_s1;
        end
    end

    generate
        for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
            al_gpio_debounce #(
                .DEB_CYCLES(DEB_CYCLES)
            ) u_deb (
                .clk   (ppm_clk),
                .rst_n (rst_n),
                .din   (sync_s2[i]),
                .filt  (filt[i])
            );
        end
    endgenerate

    // Edge detect stage on the filtered level
    always_ff @(posedge ppm_clk or negedge rst_n) begin
        if (!rst_n) begin
            filt_q <= '0;
        end else begin
            filt_q <= filt;
        end
    end

    assign rise = filt & ~filt_q;
    assign fall = ~filt & filt_q;

    // A new edge in the same cycle as a W1C of that bit keeps the bit set.
    always_comb begin
        stat_clr = '0;
        if (reg_wr && (reg_addr == ADDR_IRQ_STAT)) begin
            stat_clr = reg_wdata;
        end
        irq_stat_next = (irq_stat & ~stat_clr) | (rise & rise_en) | (fall & fall_en);
    end

    always_comb begin
        rdata_next = '0;
        case (reg_addr)
            ADDR_DATA_OUT: rdata_next = data_out;
            ADDR_DIR:      rdata_next = dir;
            ADDR_DATA_IN:  rdata_next = filt;
            ADDR_RISE_EN:  rdata_next = rise_en;
            ADDR_FALL_EN:  rdata_next = fall_en;
            ADDR_IRQ_STAT: rdata_next = irq_stat;
            default:       rdata_next = '0;
        endcase
    end

    // Register file and read response stage
    always_ff @(posedge ppm_clk or negedge rst_n) begin
        if (!rst_n) begin
            data_out   <= '0;
            dir        <= '0;
            rise_en    <= '0;
            fall_en    <= '0;
            irq_stat   <= '0;
            irq        <= 1'b0;
            reg_rdata  <= '0;
            reg_rvalid <= 1'b0;
        end else begin
            irq_stat <= irq_stat_next;
            irq      <= |irq_stat_next;

            if (reg_wr) begin
                case (reg_addr)
                    ADDR_DATA_OUT: data_out <= reg_wdata;
                    ADDR_DIR:      dir      <= reg_wdata;
                    ADDR_RISE_EN:  rise_en  <= reg_wdata;
                    ADDR_FALL_EN:  fall_en  <= reg_wdata;
                    ADDR_OUT_SET:  data_out <= data_out | reg_wdata;
                    ADDR_OUT_CLR:  data_out <= data_out & ~reg_wdata;
                    default:       ;
                endcase
            end

            if (reg_rd && !reg_wr) begin
                reg_rdata  <= rdata_next;
                reg_rvalid <= 1'b1;
            end else begin
                reg_rvalid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_al_mcu_gpio_bank.sv
// Self-checking bench for al_mcu_gpio_bank: read expectations are queued when a
// read is issued and compared when the matching rvalid pulse appears.
module tb_al_mcu_gpio_bank;
    import al_mcu_gpio_pkg::*;

    localparam int NUM_CH     = 16;
    localparam int DEB_CYCLES = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              reg_wr;
    logic              reg_rd;
    logic [ADDR_W-1:0] reg_addr;
    logic [NUM_CH-1:0] reg_wdata;
    logic [NUM_CH-1:0] reg_rdata;
    logic              reg_rvalid;
    logic [NUM_CH-1:0] gpio_in;
    logic [NUM_CH-1:0] gpio_out;
    logic [NUM_CH-1:0] gpio_oe_n;
    logic              irq;

    int checks = 0;
    int errors = 0;

    logic [NUM_CH-1:0] exp_q[$];
    logic [ADDR_W-1:0] addr_q[$];
    logic [NUM_CH-1:0] mon_exp;
    logic [ADDR_W-1:0] mon_addr;

    always #5 clk = ~clk;

    al_mcu_gpio_bank #(
        .NUM_CH     (NUM_CH),
        .DEB_CYCLES (DEB_CYCLES)
    ) dut (
        .ppm_clk    (clk),
        .rst_n      (rst_n),
        .reg_wr     (reg_wr),
        .reg_rd     (reg_rd),
        .reg_addr   (reg_addr),
        .reg_wdata  (reg_wdata),
        .reg_rdata  (reg_rdata),
        .reg_rvalid (reg_rvalid),
        .gpio_in    (gpio_in),
        .gpio_out   (gpio_out),
        .gpio_oe_n  (gpio_oe_n),
        .irq        (irq)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        if (obs !== expv) begin
            errors++;
            $display("FAIL %s got 0x%0h expected 0x%0h at %0t", tag, obs, expv, $time);
        end
    endtask

    task automatic tick(input int n = 1);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wr(input logic [ADDR_W-1:0] a, input logic [NUM_CH-1:0] d);
        reg_wr    = 1'b1;
        reg_addr  = a;
        reg_wdata = d;
        tick();
        reg_wr    = 1'b0;
    endtask

    task automatic rd(input logic [ADDR_W-1:0] a, input logic [NUM_CH-1:0] e);
        reg_rd   = 1'b1;
        reg_addr = a;
        exp_q.push_back(e);
        addr_q.push_back(a);
        tick();
        reg_rd   = 1'b0;
    endtask

    // Scoreboard side: every rvalid pulse consumes one queued expectation.
    always @(negedge clk) begin
        if (rst_n && reg_rvalid) begin
            if (exp_q.size() == 0) begin
                chk("rvalid_unexpected", 32'(reg_rvalid), 32'd0);
            end else begin
                mon_exp  = exp_q.pop_front();
                mon_addr = addr_q.pop_front();
                chk($sformatf("rd_addr%0d", mon_addr), 32'(reg_rdata), 32'(mon_exp));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "timeout");
    end

    initial begin
        logic [NUM_CH-1:0] out_model;

        rst_n     = 1'b0;
        reg_wr    = 1'b0;
        reg_rd    = 1'b0;
        reg_addr  = '0;
        reg_wdata = '0;
        gpio_in   = '0;

        // Reset held while pins toggle
        for (int k = 0; k < 4; k++) begin
            gpio_in = ~gpio_in;
            tick();
        end
        chk("rst_oe_n", 32'(gpio_oe_n), 32'h0000_FFFF);
        chk("rst_gpio_out", 32'(gpio_out), 32'd0);
        chk("rst_irq", 32'(irq), 32'd0);
        chk("rst_rvalid", 32'(reg_rvalid), 32'd0);
        gpio_in = '0;
        rst_n   = 1'b1;
        tick(3);
        for (int a = 0; a < 8; a++) begin
            rd(ADDR_W'(a), '0);
        end
        tick(2);

        // Output path
        out_model = 16'h0F0F;
        wr(ADDR_DIR, 16'h00FF);
        wr(ADDR_DATA_OUT, out_model);
        wr(ADDR_OUT_SET, 16'hF000);
        out_model = out_model | 16'hF000;
        wr(ADDR_OUT_CLR, 16'h000F);
        out_model = out_model & ~16'h000F;
        chk("oe_n", 32'(gpio_oe_n), 32'h0000_FF00);
        chk("gpio_out", 32'(gpio_out), 32'(out_model));
        chk("gpio_out_value", 32'(gpio_out), 32'h0000_FF00);
        rd(ADDR_DATA_OUT, out_model);
        rd(ADDR_DIR, 16'h00FF);
        rd(ADDR_OUT_SET, '0);
        rd(ADDR_OUT_CLR, '0);
        wr(ADDR_DATA_IN, 16'hFFFF);
        rd(ADDR_DATA_IN, '0);

        // Debounce: short glitch rejected, then exact acceptance latency
        gpio_in[0] = 1'b1;
        tick(3);
        gpio_in[0] = 1'b0;
        tick(8);
        rd(ADDR_DATA_IN, '0);
        tick(2);
        gpio_in[0] = 1'b1;
        tick(5);
        rd(ADDR_DATA_IN, 16'h0000);
        rd(ADDR_DATA_IN, 16'h0001);

        // Edge interrupts
        gpio_in = 16'h0002;
        tick(12);
        wr(ADDR_RISE_EN, 16'h0001);
        wr(ADDR_FALL_EN, 16'h0002);
        rd(ADDR_IRQ_STAT, '0);
        gpio_in = 16'h0005;
        tick(10);
        gpio_in = 16'h0001;
        tick(10);
        gpio_in = 16'h0005;
        tick(10);
        chk("irq_set", 32'(irq), 32'd1);
        rd(ADDR_IRQ_STAT, 16'h0003);
        wr(ADDR_IRQ_STAT, 16'h0001);
        rd(ADDR_IRQ_STAT, 16'h0002);
        chk("irq_after_w1c0", 32'(irq), 32'd1);
        wr(ADDR_IRQ_STAT, 16'h0002);
        chk("irq_clear", 32'(irq), 32'd0);
        rd(ADDR_IRQ_STAT, '0);

        // W1C colliding with a rising edge on the same bit
        gpio_in = 16'h0004;
        tick(12);
        rd(ADDR_IRQ_STAT, '0);
        gpio_in = 16'h0005;
        tick(6);
        wr(ADDR_IRQ_STAT, 16'h0001);
        chk("collide_irq", 32'(irq), 32'd1);
        rd(ADDR_IRQ_STAT, 16'h0001);
        wr(ADDR_IRQ_STAT, 16'hFFFF);

        // Reset pulse while pin 0 is mid-debounce
        gpio_in = 16'h0004;
        tick(12);
        wr(ADDR_IRQ_STAT, 16'hFFFF);
        tick(2);
        gpio_in = 16'h0005;
        tick(2);
        rst_n = 1'b0;
        #1;
        chk("midrst_oe_n", 32'(gpio_oe_n), 32'h0000_FFFF);
        chk("midrst_out", 32'(gpio_out), 32'd0);
        tick(2);
        rst_n = 1'b1;
        tick(12);
        chk("postrst_irq", 32'(irq), 32'd0);
        rd(ADDR_IRQ_STAT, '0);
        rd(ADDR_DATA_IN, 16'h0005);
        rd(ADDR_RISE_EN, '0);

        // Simultaneous write and read strobes
        reg_wr    = 1'b1;
        reg_rd    = 1'b1;
        reg_addr  = ADDR_RISE_EN;
        reg_wdata = 16'h0005;
        tick();
        reg_wr = 1'b0;
        reg_rd = 1'b0;
        chk("rdwr_rvalid", 32'(reg_rvalid), 32'd0);
        rd(ADDR_RISE_EN, 16'h0005);

        for (int k = 0; k < 10 && exp_q.size() != 0; k++) begin
            tick();
        end
        chk("drain", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
